// File: rtl/adc_range_scan_sequencer.sv
// Range-monitor scan sequencer: issues latch/shift CSR commands, waits for each to settle,
// and captures the readout words into a double-buffered bank published atomically per scan.
module adc_range_scan_sequencer #(
  parameter int unsigned AXI_CHANNEL_COUNT     = 2,
  parameter int unsigned AXI_SAMPLES_PER_CLOCK = 4,
  parameter int unsigned ADC_WIDTH             = 14,
  parameter int unsigned SETTLE_CYCLES         = 8,
  localparam int unsigned WORD_COUNT = 2 * AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK,
  localparam int unsigned ADDR_W     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
  input  logic              sysClk,
  input  logic              sysReset_n,
  input  logic              startStrobe,
  input  logic              autoEnable,
  input  logic [31:0]       periodTicks,
  input  logic              clearStrobe,
  output logic              rangeCsrStrobe,
  output logic [31:0]       rangeGpioOut,
  input  logic [31:0]       rangeReadout,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [31:0]       rdData,
  output logic              busy,
  output logic              valid,
  output logic              overrun,
  output logic [15:0]       scanCount
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_CAPTURE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [ADDR_W-1:0]           r_word_idx;
  logic [SETTLE_W-1:0]         r_wait_cnt;
  logic [31:0]                 r_interval;
  logic                        r_pub;
  logic signed [ADC_WIDTH-1:0] r_bank [2][WORD_COUNT];

  logic [31:0]                 w_period;
  logic                        w_expire;
  logic                        w_trigger;
  logic                        w_last_word;
  logic                        w_settled;
  logic signed [ADC_WIDTH-1:0] w_value;
  logic                        w_unused_readout;

  assign w_period    = (periodTicks == 32'd0) ? 32'd1 : periodTicks;
  assign w_expire    = autoEnable && (r_interval == (w_period - 32'd1));
  assign w_trigger   = startStrobe || w_expire;
  assign w_last_word = (r_word_idx == ADDR_W'(WORD_COUNT - 1));
  assign w_settled   = (r_wait_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign w_unused_readout = ^rangeReadout;

  // Narrow converters are MSB-aligned at bit 15; wide ones are LSB-aligned.
  generate
    if (ADC_WIDTH <= 16) begin : g_upper_aligned
      assign w_value = rangeReadout[15 -: ADC_WIDTH];
    end else begin : g_lower_aligned
      assign w_value = rangeReadout[ADC_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_trigger) w_next_state = S_LATCH;
      S_LATCH:   w_next_state = S_WAIT;
      S_SHIFT:   w_next_state = S_WAIT;
      S_WAIT:    if (w_settled) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = w_last_word ? S_DONE : S_SHIFT;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Command outputs and status registered from the next state so they align with it.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      rangeCsrStrobe <= 1'b0;
      rangeGpioOut   <= 32'h0;
      busy           <= 1'b0;
      valid          <= 1'b0;
      overrun        <= 1'b0;
      scanCount      <= 16'h0;
      r_pub          <= 1'b0;
      r_word_idx     <= '0;
      r_wait_cnt     <= '0;
      r_interval     <= 32'h0;
    end else begin
      rangeCsrStrobe <= (w_next_state == S_LATCH) || (w_next_state == S_SHIFT);
      if (w_next_state == S_LATCH) begin
        rangeGpioOut <= 32'h1;
      end else if (w_next_state == S_SHIFT) begin
        rangeGpioOut <= 32'h2;
      end else begin
        rangeGpioOut <= 32'h0;
      end
      busy <= (w_next_state != S_IDLE);

      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + SETTLE_W'(1) : '0;

      if ((r_state == S_IDLE) && w_trigger) begin
        r_word_idx <= '0;
      end else if ((r_state == S_CAPTURE) && !w_last_word) begin
        r_word_idx <= r_word_idx + ADDR_W'(1);
      end

      if (!autoEnable || w_expire) begin
        r_interval <= 32'h0;
      end else begin
        r_interval <= r_interval + 32'd1;
      end

      // A fresh overrun wins over a simultaneous clear.
      if (w_trigger && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end else if (clearStrobe) begin
        overrun <= 1'b0;
      end

      if (r_state == S_DONE) begin
        r_pub     <= ~r_pub;
        valid     <= 1'b1;
        scanCount <= scanCount + 16'd1;
      end
    end
  end

  // Result storage: writes always target the back bank.
  always_ff @(posedge sysClk) begin
    if (r_state == S_CAPTURE) begin
      r_bank[~r_pub][r_word_idx] <= w_value;
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      rdData <= 32'h0;
    end else if (32'(rdAddr) < WORD_COUNT) begin
      rdData <= 32'(r_bank[r_pub][rdAddr]);
    end else begin
      rdData <= 32'h0;
    end
  end

endmodule
